// File: rtl/display_source_scheduler.sv
// rtl/display_source_scheduler.sv - two-source round-robin display scheduler with double-dabble BCD conversion
// Defining SCHED_HOLD_EN adds a hold input that freezes dwell-based rotation.
module display_source_scheduler #(
   parameter int VAL_W        = 10,
   parameter int DWELL_CYCLES = 50000000,
   parameter int DWELL_W      = 26
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [VAL_W-1:0] src0_value,
   input  logic             src0_valid,
   input  logic [VAL_W-1:0] src1_value,
   input  logic             src1_valid,
`ifdef SCHED_HOLD_EN
   input  logic             hold,
`endif
   output logic [3:0]       digit0,
   output logic [3:0]       digit1,
   output logic [3:0]       digit2,
   output logic             active_src,
   output logic             conv_busy
);

   localparam int                 CNT_W      = $clog2(VAL_W + 1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(VAL_W - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;
   state_t state, state_next;

   logic [DWELL_W-1:0] dwell_cnt;
   logic               switch_pending;
   logic [CNT_W-1:0]   shift_cnt;
   logic [VAL_W-1:0]   bin_reg;
   logic [11:0]        bcd_reg;
   logic [11:0]        bcd_adj;
   logic               snap_valid;
   logic               snap_over;

   logic               dwell_run;
   logic               dwell_expire;
   logic               cur_valid;
   logic               other_valid;
   logic               do_toggle;
   logic               sel_src;
   logic               sel_valid;
   logic [VAL_W-1:0]   sel_value;

`ifdef SCHED_HOLD_EN
   assign dwell_run = !hold;
`else
   assign dwell_run = 1'b1;
`endif
   assign dwell_expire = dwell_run && (dwell_cnt == DWELL_LAST);

   // A dwell switch and an invalid-source fallback collapse into one toggle.
   always_comb begin
      cur_valid   = active_src ? src1_valid : src0_valid;
      other_valid = active_src ? src0_valid : src1_valid;
      do_toggle   = other_valid && (switch_pending || !cur_valid);
      sel_src     = active_src ^ do_toggle;
      sel_value   = sel_src ? src1_value : src0_value;
      sel_valid   = sel_src ? src1_valid : src0_valid;
   end

   always_comb begin
      bcd_adj = bcd_reg;
      for (int i = 0; i < 3; i++) begin
         if (bcd_reg[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_next = state;
      conv_busy  = 1'b0;
      case (state)
         IDLE:  state_next = LOAD;
         LOAD: begin
            conv_busy  = 1'b1;
            state_next = SHIFT;
         end
         SHIFT: begin
            conv_busy = 1'b1;
            if (shift_cnt == CNT_LAST)
               state_next = LATCH;
         end
         LATCH: state_next = LOAD;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // An expiry coinciding with LOAD wins over the clear so it is not lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dwell_cnt      <= '0;
         switch_pending <= 1'b0;
      end else begin
         if (dwell_run)
            dwell_cnt <= dwell_expire ? '0 : dwell_cnt + 1'b1;
         if (dwell_expire)
            switch_pending <= 1'b1;
         else if (state == LOAD)
            switch_pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active_src <= 1'b0;
         shift_cnt  <= '0;
         bin_reg    <= '0;
         bcd_reg    <= '0;
         snap_valid <= 1'b0;
         snap_over  <= 1'b0;
         digit0     <= 4'hF;
         digit1     <= 4'hF;
         digit2     <= 4'hF;
      end else begin
         case (state)
            LOAD: begin
               active_src <= sel_src;
               bin_reg    <= sel_value;
               bcd_reg    <= '0;
               snap_valid <= sel_valid;
               snap_over  <= (32'(sel_value) > 32'd999);
               shift_cnt  <= '0;
            end
            SHIFT: begin
               {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
               shift_cnt <= (shift_cnt == CNT_LAST) ? '0 : shift_cnt + 1'b1;
            end
            LATCH: begin
               if (!snap_valid || snap_over) begin
                  digit0 <= 4'hF;
                  digit1 <= 4'hF;
                  digit2 <= 4'hF;
               end else begin
                  digit0 <= bcd_reg[3:0];
                  digit1 <= bcd_reg[7:4];
                  digit2 <= bcd_reg[11:8];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_display_source_scheduler.sv
// tb/tb_display_source_scheduler.sv - randomized bench for display_source_scheduler against a cycle model
module tb_display_source_scheduler;

   localparam int DWELL = 64;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [9:0] src0_value;
   logic       src0_valid;
   logic [9:0] src1_value;
   logic       src1_valid;
   logic       hold;
   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic       active_src;
   logic       conv_busy;
   logic [13:0] dut_vec;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   display_source_scheduler #(
      .VAL_W(10),
      .DWELL_CYCLES(DWELL),
      .DWELL_W(8)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .src0_value(src0_value),
      .src0_valid(src0_valid),
      .src1_value(src1_value),
      .src1_valid(src1_valid),
`ifdef SCHED_HOLD_EN
      .hold(hold),
`endif
      .digit0(digit0),
      .digit1(digit1),
      .digit2(digit2),
      .active_src(active_src),
      .conv_busy(conv_busy)
   );

   assign dut_vec = {digit2, digit1, digit0, active_src, conv_busy};

   // Reference model: refresh period of 12 cycles (phase 0 = LOAD, 1..10 = SHIFT, 11 = LATCH).
   bit         m_started;
   int         m_phase;
   int         m_dwell;
   bit         m_pending;
   bit         m_active;
   int         m_snap_val;
   bit         m_snap_valid;
   logic [3:0] m_d0, m_d1, m_d2;

   function automatic logic [11:0] to_bcd(int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [13:0] exp_vec();
      return {m_d2, m_d1, m_d0, m_active, m_started && (m_phase != 11)};
   endfunction

   task automatic model_reset();
      m_started = 0; m_phase = 0; m_dwell = 0; m_pending = 0; m_active = 0;
      m_snap_val = 0; m_snap_valid = 0;
      m_d0 = 4'hF; m_d1 = 4'hF; m_d2 = 4'hF;
   endtask

   task automatic model_edge();
      bit load_now, expire, cur, other;
      load_now = m_started && (m_phase == 0);
      expire   = !hold && (m_dwell == DWELL - 1);
      if (!m_started) begin
         m_started = 1;
         m_phase   = 0;
      end else if (m_phase == 0) begin
         cur   = m_active ? src1_valid : src0_valid;
         other = m_active ? src0_valid : src1_valid;
         if (other && (m_pending || !cur))
            m_active = !m_active;
         m_snap_val   = m_active ? int'(src1_value) : int'(src0_value);
         m_snap_valid = m_active ? src1_valid : src0_valid;
         m_phase = 1;
      end else if (m_phase < 11) begin
         m_phase++;
      end else begin
         if (!m_snap_valid || m_snap_val > 999)
            {m_d2, m_d1, m_d0} = 12'hFFF;
         else
            {m_d2, m_d1, m_d0} = to_bcd(m_snap_val);
         m_phase = 0;
      end
      if (!hold)
         m_dwell = (m_dwell == DWELL - 1) ? 0 : m_dwell + 1;
      if (expire)
         m_pending = 1;
      else if (load_now)
         m_pending = 0;
   endtask

   always @(posedge clk) begin
      if (reset_n)
         model_edge();
   end

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; hold = 1'b0;
      src0_value = '0; src0_valid = 1'b0; src1_value = '0; src1_valid = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (dut_vec !== 14'h3FFC) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", dut_vec, 14'h3FFC);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      src0_value = 10'd123; src0_valid = 1'b1; src1_value = 10'd555; src1_valid = 1'b0;
      do_reset();
      for (int i = 1; i <= 13; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL single_model cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         if (i == 12) begin
            checks++;
            if ({digit2, digit1, digit0} !== 12'hFFF) begin
               errors++;
               $display("FAIL single_early: got %h expected fff", {digit2, digit1, digit0});
            end
         end
      end
      checks++;
      if ({digit2, digit1, digit0, active_src} !== 13'h0246) begin
         errors++;
         $display("FAIL single_123: got %h expected 0246", {digit2, digit1, digit0, active_src});
      end
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec() || active_src !== 1'b0) begin
            errors++;
            $display("FAIL single_hold cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_rotation();
      bit seen_a, seen_b;
      int toggles;
      logic last_act;
      src0_value = 10'd45; src0_valid = 1'b1; src1_value = 10'd907; src1_valid = 1'b1;
      do_reset();
      seen_a = 0; seen_b = 0; toggles = 0; last_act = 1'b0;
      for (int i = 0; i < 640; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL rotation cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         if ({digit2, digit1, digit0} == 12'h045) seen_a = 1;
         if ({digit2, digit1, digit0} == 12'h907) seen_b = 1;
         if (active_src !== last_act) toggles++;
         last_act = active_src;
      end
      checks++;
      if (!(seen_a && seen_b) || toggles < 9 || toggles > 10) begin
         errors++;
         $display("FAIL rotation_summary: seen %0d%0d toggles %0d expected 11 and 9..10", seen_a, seen_b, toggles);
      end
   endtask

   task automatic test_boundary();
      int          vals [4];
      logic [11:0] want [4];
      vals[0] = 1000; vals[1] = 999; vals[2] = 0; vals[3] = 1023;
      want[0] = 12'hFFF; want[1] = 12'h999; want[2] = 12'h000; want[3] = 12'hFFF;
      src1_valid = 1'b0; src0_valid = 1'b1;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         src0_value = 10'(vals[k]);
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
               errors++;
               $display("FAIL boundary_model %0d cycle %0d: got %h expected %h", vals[k], i, dut_vec, exp_vec());
            end
         end
         checks++;
         if ({digit2, digit1, digit0} !== want[k]) begin
            errors++;
            $display("FAIL boundary_%0d: got %h expected %h", vals[k], {digit2, digit1, digit0}, want[k]);
         end
      end
   endtask

   task automatic test_drop();
      int v;
      src0_value = 10'($urandom_range(0, 999)); src1_value = 10'($urandom_range(0, 999));
      src0_valid = 1'b1; src1_valid = 1'b1;
      do_reset();
      for (int k = 0; k < 1000 && !(m_active && m_phase >= 3 && m_phase <= 8); k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL drop_pre cycle %0d: got %h expected %h", k, dut_vec, exp_vec());
         end
      end
      checks++;
      if (!(m_active && m_phase >= 3 && m_phase <= 8)) begin
         errors++;
         $display("FAIL drop_wait: timed out waiting for src1 shift, active %0d phase %0d", m_active, m_phase);
      end
      v = int'(src1_value);
      src1_valid = 1'b0;
      for (int k = 0; k < 20 && m_phase != 0; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL drop_flight cycle %0d: got %h expected %h", k, dut_vec, exp_vec());
         end
      end
      checks++;
      if ({digit2, digit1, digit0, active_src} !== {to_bcd(v), 1'b1}) begin
         errors++;
         $display("FAIL drop_snapshot: got %h expected %h", {digit2, digit1, digit0, active_src}, {to_bcd(v), 1'b1});
      end
      repeat (2) @(negedge clk);
      checks++;
      if (active_src !== 1'b0) begin
         errors++;
         $display("FAIL drop_fallback: got %0d expected 0", active_src);
      end
      src0_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL drop_both cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
      checks++;
      if ({digit2, digit1, digit0, active_src} !== 13'h1FFE) begin
         errors++;
         $display("FAIL drop_blank: got %h expected 1ffe", {digit2, digit1, digit0, active_src});
      end
   endtask

   task automatic test_reset_mid();
      src0_value = 10'($urandom_range(0, 999)); src1_value = 10'($urandom_range(0, 999));
      src0_valid = 1'b1; src1_valid = 1'b1;
      do_reset();
      repeat (20) @(negedge clk);
      for (int k = 0; k < 20 && m_phase != 5; k++) @(negedge clk);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_vec !== 14'h3FFC) begin
         errors++;
         $display("FAIL reset_async: got %h expected 3ffc", dut_vec);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid_model cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
      checks++;
      if ({digit2, digit1, digit0, active_src} !== {to_bcd(int'(src0_value)), 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_result: got %h expected %h", {digit2, digit1, digit0, active_src}, {to_bcd(int'(src0_value)), 1'b0});
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            src0_value = 10'($urandom_range(0, 1023));
            src1_value = 10'($urandom_range(0, 1023));
            src0_valid = ($urandom_range(0, 3) != 0);
            src1_valid = ($urandom_range(0, 3) != 0);
         end
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
   endtask

`ifdef SCHED_HOLD_EN
   task automatic test_hold();
      logic held_act;
      bit   moved;
      src0_value = 10'd321; src1_value = 10'd654; src0_valid = 1'b1; src1_valid = 1'b1;
      hold = 1'b0;
      do_reset();
      repeat (30) @(negedge clk);
      hold = 1'b1;
      held_act = active_src;
      moved = 0;
      for (int i = 0; i < 3 * DWELL; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL hold_model cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         if (active_src !== held_act) moved = 1;
      end
      checks++;
      if (moved) begin
         errors++;
         $display("FAIL hold_frozen: active changed, expected %0d", held_act);
      end
      hold = 1'b0;
      for (int i = 0; i < 2 * DWELL; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL hold_release cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_boundary();
      test_drop();
      test_reset_mid();
      test_random();
`ifdef SCHED_HOLD_EN
      test_hold();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
